// File: rtl/pipelined_add_sub.sv
// Carry-pipelined two's-complement adder/subtractor.
// A WIDTH-bit add or subtract is split into WIDTH/CHUNK chunk adders, one per
// pipeline stage, so the carry ripples one chunk per clock. Upper operand
// chunks are skewed forward through the stages. Finished lower result chunks
// travel alongside them in the same word. Back-pressure is global: the whole
// pipe freezes while a valid result waits for out_ready.
// WIDTH must be a multiple of CHUNK, and CHUNK must not exceed WIDTH.
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_barrow,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  // Stage inputs: either the ports (stage 0) or the previous stage's registers.
  logic [WIDTH-1:0] word_in  [STAGES];
  logic [WIDTH-1:0] b_in     [STAGES];
  logic             carry_in [STAGES];
  logic             valid_in [STAGES];

  // Stage register contents, gathered so that the next stage can read them.
  logic [WIDTH-1:0] stage_word  [STAGES];
  logic [WIDTH-1:0] stage_b     [STAGES];
  logic             stage_carry [STAGES];
  logic             stage_valid [STAGES];

  logic advance;

  // The pipe moves unless the output holds an unconsumed result.
  assign advance  = !stage_valid[STAGES-1] || out_ready;
  assign in_ready = advance;

  assign out_valid    = stage_valid[STAGES-1];
  assign dout         = stage_word[STAGES-1];
  assign carry_barrow = stage_carry[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] CHUNK_MASK = LOW_MASK << (gi * CHUNK);

      logic [CHUNK:0]   chunk_sum;
      logic [WIDTH-1:0] sum_ext;
      logic [WIDTH-1:0] word_next;

      logic             valid_reg;
      logic [WIDTH-1:0] word_reg;
      logic             carry_reg;

      if (gi == 0) begin : g_src
        // b is conditioned once on entry; sel is the carry-in of chunk 0.
        assign word_in[gi]  = a;
        assign b_in[gi]     = b ^ {WIDTH{sel}};
        assign carry_in[gi] = sel;
        assign valid_in[gi] = in_valid;
      end else begin : g_src
        assign word_in[gi]  = stage_word[gi-1];
        assign b_in[gi]     = stage_b[gi-1];
        assign carry_in[gi] = stage_carry[gi-1];
        assign valid_in[gi] = stage_valid[gi-1];
      end

      // Resolve chunk gi. The operand chunk of a in the word is replaced by
      // the result chunk, so lower result bits and upper a bits share a word.
      assign chunk_sum = {1'b0, word_in[gi][gi*CHUNK +: CHUNK]}
                       + {1'b0, b_in[gi][gi*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, carry_in[gi]};
      assign sum_ext   = WIDTH'(chunk_sum[CHUNK-1:0]);
      assign word_next = (word_in[gi] & ~CHUNK_MASK) | (sum_ext << (gi * CHUNK));

      // Stage register: freezes with the pipe; data loads only with a valid transaction.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          word_reg  <= '0;
          carry_reg <= 1'b0;
        end else if (advance) begin
          valid_reg <= valid_in[gi];
          if (valid_in[gi]) begin
            word_reg  <= word_next;
            carry_reg <= chunk_sum[CHUNK];
          end
        end
      end

      assign stage_word[gi]  = word_reg;
      assign stage_carry[gi] = carry_reg;
      assign stage_valid[gi] = valid_reg;

      if (gi < STAGES - 1) begin : g_skew
        logic [WIDTH-1:0] b_reg;

        // Carry the conditioned b forward for the stages still to come.
        always_ff @(posedge clk) begin
          if (rst) begin
            b_reg <= '0;
          end else if (advance && valid_in[gi]) begin
            b_reg <= b_in[gi];
          end
        end

        assign stage_b[gi] = b_reg;
      end else begin : g_last
        logic msb_carry_in;
        logic overflow_reg;

        // Carry into the MSB recovered from its sum bit; V = carry in ^ carry out.
        assign msb_carry_in = word_in[gi][WIDTH-1] ^ b_in[gi][WIDTH-1] ^ word_next[WIDTH-1];

        // Overflow flag lands together with dout and carry_barrow.
        always_ff @(posedge clk) begin
          if (rst) begin
            overflow_reg <= 1'b0;
          end else if (advance && valid_in[gi]) begin
            overflow_reg <= msb_carry_in ^ chunk_sum[CHUNK];
          end
        end

        assign stage_b[gi] = '0;
        assign overflow    = overflow_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, CHUNK=4, latency 4).
// A queue-based arithmetic model predicts every result from plain signed and
// unsigned integer arithmetic. Directed sequences cover the corner cases and
// carry hand-computed literal expectations.
module tb_pipelined_add_sub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             carry_barrow;
  logic             overflow;

  pipelined_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .carry_barrow(carry_barrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        v;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: integer sum/difference, unsigned carry/no-borrow, signed range test.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    res_t r;
    int sx, sy, sr;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      r.d = x - y;
      r.c = (x >= y);
      sr  = sx - sy;
    end else begin
      r.d = x + y;
      r.c = (int'(x) + int'(y)) > 65535;
      sr  = sx + sy;
    end
    r.v = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  // Scoreboard: every accepted operand set is predicted; every presented result is checked.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_valid, 1'b0);
        end else begin
          check("sb_dout", dout, exp_q[0].d);
          check("sb_carry", carry_barrow, exp_q[0].c);
          check("sb_overflow", overflow, exp_q[0].v);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sel));
    end
  end

  task automatic run_one(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic [15:0] ed, input logic ec, input logic ev);
    int lat;
    a = x; b = y; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 4);
    check({nm, "_dout"}, dout, ed);
    check({nm, "_carry"}, carry_barrow, ec);
    check({nm, "_overflow"}, overflow, ev);
    @(posedge clk); #1;
    check({nm, "_drained"}, out_valid, 1'b0);
    $display("txn %s: a=%h b=%h sel=%0d -> dout=%h c=%0d v=%0d latency=%0d",
             nm, x, y, s, dout, carry_barrow, overflow, lat);
  endtask

  logic [15:0] va[8] = '{16'h1234, 16'h1234, 16'h8000, 16'h0000,
                         16'h7FFF, 16'h7FFF, 16'hABCD, 16'hFFFF};
  logic [15:0] vb[8] = '{16'h4321, 16'h4321, 16'h8000, 16'h0001,
                         16'h7FFF, 16'hFFFF, 16'h5433, 16'hFFFF};

  initial begin
    int   idx, got, stall_left;
    bit   stalled, acc, cons;
    logic ov_seen[8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_dout", dout, 16'h0000);
    check("reset_carry", carry_barrow, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single transactions with hand-computed results.
    run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream with alternating sel and a 3-cycle stall after result 2.
    idx = 0; got = 0; stall_left = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (!stalled && got == 2) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a = va[idx]; b = vb[idx]; sel = idx[0];
      end
      @(negedge clk);
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (stall_left > 0) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
      end
      if (cons) $display("txn stream#%0d: dout=%h c=%0d v=%0d", got, dout, carry_barrow, overflow);
      @(posedge clk); #1;
      if (acc) idx++;
      if (cons) got++;
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", got, 8);
    check("stream_accepted", idx, 8);
    repeat (2) @(posedge clk); #1;

    // Bubbles: in_valid 1,0,0,1 -> out_valid 1,0,0,1 four cycles later.
    a = 16'h1234; b = 16'h1111; sel = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      ov_seen[j] = out_valid;
      if (j == 4 || j == 5) check("bubble_dout_hold", dout, 16'h2345);
      if (j == 6) check("bubble_dout_second", dout, 16'hFF00);
      in_valid = (j == 2);
      if (j == 2) begin
        a = 16'h0100; b = 16'h0200; sel = 1'b1;
      end
    end
    for (int j = 0; j < 8; j++) check("bubble_out_valid", ov_seen[j], (j == 3) || (j == 6));
    $display("txn bubbles: out_valid pattern %0d%0d%0d%0d%0d%0d%0d%0d",
             ov_seen[0], ov_seen[1], ov_seen[2], ov_seen[3],
             ov_seen[4], ov_seen[5], ov_seen[6], ov_seen[7]);

    // Reset with three transactions in flight and a fourth offered during reset.
    for (int j = 0; j < 3; j++) begin
      a = 16'h0F0F + 16'(j); b = 16'h1010; sel = j[0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    a = 16'h5555; b = 16'h2222; sel = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_dout", dout, 16'h0000);
    check("flush_carry", carry_barrow, 1'b0);
    check("flush_overflow", overflow, 1'b0);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      check("flush_no_leak", out_valid, 1'b0);
    end
    $display("txn flush: pipeline cleared, no flushed result emitted");
    run_one("post_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    repeat (2) @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
